// File: rtl/decoder38_pulse.sv
// Pulsed one-hot decoder: a code taken over valid/ready drives y for PULSE_LEN cycles.
// Define DECODER38_PENDING_EN to add a one-entry pending code for gapless strobes.
module decoder38_pulse #(
    parameter int CODE_W    = 3,
    parameter int PULSE_LEN = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   code_valid,
    input  logic [CODE_W-1:0]      code,
    output logic                   code_ready,
    output logic [(2**CODE_W)-1:0] y,
    output logic                   y_valid,
    output logic                   done
);

    localparam int OUT_W   = 2**CODE_W;
    localparam int CNT_RAW = $clog2(PULSE_LEN + 1);
    localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_LEN - 1);

    if (PULSE_LEN < 1 || PULSE_LEN > 255) begin : g_bad_len
        $error("decoder38_pulse: PULSE_LEN=%0d outside 1..255", PULSE_LEN);
    end

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [OUT_W-1:0]  y_n;
    logic              y_valid_n;
    logic              done_n;
    logic              accept;

`ifdef DECODER38_PENDING_EN
    logic              pend_valid, pend_valid_n;
    logic [CODE_W-1:0] pend_code, pend_code_n;
`endif

    function automatic logic [OUT_W-1:0] onehot(input logic [CODE_W-1:0] c);
        return OUT_W'(1) << c;
    endfunction

    always_comb begin
        code_ready = 1'b0;
        unique case (state)
            IDLE: code_ready = rst_n && en;
`ifdef DECODER38_PENDING_EN
            HOLD: code_ready = rst_n && en && !pend_valid;
`else
            HOLD: code_ready = 1'b0;
`endif
        endcase
    end

    assign accept = code_valid && code_ready;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        y_n       = y;
        y_valid_n = y_valid;
        done_n    = 1'b0;
`ifdef DECODER38_PENDING_EN
        pend_valid_n = pend_valid;
        pend_code_n  = pend_code;
`endif
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n   = HOLD;
                    y_n       = onehot(code);
                    y_valid_n = 1'b1;
                    cnt_n     = CNT_LOAD;
                end
            end
            HOLD: begin
                if (!en) begin
                    // abort: drop the strobe silently
                    state_n   = IDLE;
                    y_n       = '0;
                    y_valid_n = 1'b0;
                    cnt_n     = '0;
`ifdef DECODER38_PENDING_EN
                    pend_valid_n = 1'b0;
`endif
                end else if (cnt == '0) begin
                    done_n = 1'b1;
`ifdef DECODER38_PENDING_EN
                    if (pend_valid || accept) begin
                        y_n          = onehot(pend_valid ? pend_code : code);
                        cnt_n        = CNT_LOAD;
                        pend_valid_n = 1'b0;
                    end else begin
                        state_n   = IDLE;
                        y_n       = '0;
                        y_valid_n = 1'b0;
                    end
`else
                    state_n   = IDLE;
                    y_n       = '0;
                    y_valid_n = 1'b0;
`endif
                end else begin
                    cnt_n = cnt - 1'b1;
`ifdef DECODER38_PENDING_EN
                    if (accept) begin
                        pend_valid_n = 1'b1;
                        pend_code_n  = code;
                    end
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            y       <= '0;
            y_valid <= 1'b0;
            done    <= 1'b0;
`ifdef DECODER38_PENDING_EN
            pend_valid <= 1'b0;
            pend_code  <= '0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            y       <= y_n;
            y_valid <= y_valid_n;
            done    <= done_n;
`ifdef DECODER38_PENDING_EN
            pend_valid <= pend_valid_n;
            pend_code  <= pend_code_n;
`endif
        end
    end

endmodule

// File: tb/tb_decoder38_pulse.sv
// Scoreboard bench for decoder38_pulse: strobes queued at accept, checked as y plays out.
// PULSE_LEN=4 main instance plus a PULSE_LEN=1 instance for the single-cycle case.
module tb_decoder38_pulse;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       code_valid;
    logic [2:0] code;
    logic       code_ready;
    logic [7:0] y;
    logic       y_valid;
    logic       done;

    logic       en1;
    logic       valid1;
    logic [2:0] code1;
    logic       ready1;
    logic [7:0] y1;
    logic       yv1;
    logic       done1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] y;
        int         len;
        bit         dn;
    } strobe_t;

    typedef struct {
        logic [7:0] y;
        bit         dn;
    } beat_t;

    strobe_t sb[$];
    strobe_t cur;
    bit      active = 0;
    int      run = 0;
    beat_t   pl1_q[$];

    decoder38_pulse #(.CODE_W(3), .PULSE_LEN(4)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .code_valid (code_valid),
        .code       (code),
        .code_ready (code_ready),
        .y          (y),
        .y_valid    (y_valid),
        .done       (done)
    );

    decoder38_pulse #(.CODE_W(3), .PULSE_LEN(1)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en1),
        .code_valid (valid1),
        .code       (code1),
        .code_ready (ready1),
        .y          (y1),
        .y_valid    (yv1),
        .done       (done1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: every negedge, match the strobe on y against the scoreboard.
    always @(negedge clk) begin
        bit done_exp;
        done_exp = 1'b0;
        if (y_valid) begin
            if (active && y != cur.y) begin
                check("len", 32'(run), 32'(cur.len));
                done_exp = cur.dn;
                active = 0;
            end
            if (!active) begin
                if (sb.size() == 0) begin
                    check("unexpected_strobe", 32'(y), 32'(0));
                end else begin
                    cur = sb.pop_front();
                    check("y", 32'(y), 32'(cur.y));
                    active = 1;
                    run = 0;
                end
            end
            if (active) run++;
        end else begin
            if (active) begin
                check("len", 32'(run), 32'(cur.len));
                done_exp = cur.dn;
                active = 0;
            end
            check("y_idle", 32'(y), 32'(0));
        end
        check("done", 32'(done), 32'(done_exp));
        check("onehot", 32'($onehot0(y)), 32'(1));
    end

    task automatic send(input logic [2:0] c, input int len, input bit dn);
        int n = 0;
        while (!code_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("send_timeout", 32'(code_ready), 32'(1));
        code       = c;
        code_valid = 1'b1;
        sb.push_back('{y: 8'b1 << c, len: len, dn: dn});
        @(posedge clk);
        #1;
        code_valid = 1'b0;
        code       = ~c;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || active) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("drain_timeout", 32'(sb.size()), 32'(0));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n      = 1'b0;
        en         = 1'b1;
        code_valid = 1'b1;
        code       = 3'd5;
        en1        = 1'b1;
        valid1     = 1'b0;
        code1      = 3'd0;

        repeat (3) begin
            @(negedge clk);
            check("rst_y", 32'(y), 32'(0));
            check("rst_y_valid", 32'(y_valid), 32'(0));
            check("rst_done", 32'(done), 32'(0));
            check("rst_ready", 32'(code_ready), 32'(0));
            check("rst_ready1", 32'(ready1), 32'(0));
        end
        code_valid = 1'b0;
        rst_n      = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'(code_ready), 32'(1));

        send(3'd3, 4, 1'b1);
        drain();

        for (int c = 0; c < 8; c++) send(3'(c), 4, 1'b1);
        drain();

        send(3'd6, 4, 1'b1);
        send(3'd1, 4, 1'b1);
        drain();

        send(3'd7, 2, 1'b0);
        @(negedge clk);
        @(negedge clk);
        en         = 1'b0;
        code_valid = 1'b1;
        code       = 3'd5;
        check("abort_ready_hold", 32'(code_ready), 32'(0));
        @(negedge clk);
        check("abort_ready_idle", 32'(code_ready), 32'(0));
        repeat (2) @(negedge clk);
        code_valid = 1'b0;
        en         = 1'b1;
        send(3'd2, 4, 1'b1);
        drain();

        send(3'd3, 1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        check("midrst_ready", 32'(code_ready), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        drain();

`ifndef DECODER38_PENDING_EN
        pl1_q.push_back('{y: 8'b0001_0000, dn: 1'b0});
        pl1_q.push_back('{y: 8'b0000_0000, dn: 1'b1});
        pl1_q.push_back('{y: 8'b0000_0001, dn: 1'b0});
        pl1_q.push_back('{y: 8'b0000_0000, dn: 1'b1});
        pl1_q.push_back('{y: 8'b0000_0000, dn: 1'b0});
        valid1 = 1'b1;
        code1  = 3'd4;
        @(posedge clk);
        #1;
        code1 = 3'd0;
        for (int i = 0; i < 5; i++) begin
            beat_t e;
            @(negedge clk);
            e = pl1_q.pop_front();
            check("pl1_y", 32'(y1), 32'(e.y));
            check("pl1_yv", 32'(yv1), 32'(e.y != 8'd0));
            check("pl1_done", 32'(done1), 32'(e.dn));
            if (i == 1) begin
                @(posedge clk);
                #1;
                valid1 = 1'b0;
            end
        end
`else
        send(3'd2, 4, 1'b1);
        send(3'd5, 4, 1'b1);
        code       = 3'd7;
        code_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("pend_full_ready", 32'(code_ready), 32'(0));
        end
        code_valid = 1'b0;
        drain();
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decoder38_pulse.md
Name: decoder38_pulse

Overview:
- Sequential inverse of the team's 8-to-3 priority encoder. Takes a 3-bit code through a valid/ready handshake and drives the matching one-hot line on an 8-bit output for a programmable number of cycles.
- Used to fire per-channel strobes (interrupt acks, channel selects) from an encoded index.
- Contains a small FSM, a hold counter and a completion pulse.

Parameters:
- CODE_W, 3: code width. Output width is 2**CODE_W, derived internally and not overridable.
- PULSE_LEN, 4: cycles the one-hot output is held per accepted code. Legal range 1..255; 0 is illegal and must trip a simulation-time $error.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- en  input  1  block enable
- code_valid  input  1  code present
- code  input  CODE_W  code to decode
- code_ready  output  1  block can accept a code this cycle
- y  output  2**CODE_W  one-hot strobe, all-zero when idle
- y_valid  output  1  y currently carries a strobe
- done  output  1  one-cycle pulse marking a completed strobe

Behaviour:
- One clock: clk. Reset rst_n is synchronous and active-low; it is sampled only on the rising edge of clk.
- Reset, and the first cycle after reset: state=IDLE, counter=0, y=0, y_valid=0, done=0, code_ready=0 while rst_n=0.
- All outputs are registered, except code_ready, which is combinational from state and en.
- FSM states:
  - IDLE: code_ready = en. An accept occurs when code_valid && code_ready at an edge. On accept: state->HOLD, y <= 1<<code, y_valid <= 1, counter <= PULSE_LEN-1.
  - HOLD: code_ready=0. y and y_valid stay stable. Counter decrements each edge. At the edge where counter==0: state->IDLE, y<=0, y_valid<=0, done<=1 for exactly one cycle.
- Latency: accept at edge k -> y valid during cycles k+1 .. k+PULSE_LEN -> done high during cycle k+PULSE_LEN+1.
- Back-to-back operation: code_ready is high in the done cycle, so a new code can be accepted there. The minimum gap between strobes is exactly one all-zero cycle.
- PULSE_LEN=1: y is high for exactly one cycle, then done.
- en=0 in IDLE: code_ready=0. Any code_valid is ignored and not consumed.
- en=0 in HOLD: abort. At the next edge: state->IDLE, y=0, y_valid=0, counter=0. done is NOT asserted.
- rst_n=0 mid-HOLD: same as abort, plus all outputs go to reset values at that edge. done is not asserted.
- code is sampled only at the accept edge. Later changes to code have no effect.
- X/Z on code at accept: y is undefined in simulation only. The block never drives Z (unlike the encoder's disabled state).
- y is always either all-zero or exactly one-hot. This is a bench assertion.
- Counter width: $clog2(PULSE_LEN+1).

Optional Feature:
- Macro: DECODER38_PENDING_EN.
- Enabled: adds a one-entry pending register (pend_valid, pend_code).
  - In HOLD, code_ready = en && !pend_valid.
  - An accept in HOLD loads the pending register.
  - At the terminal HOLD edge with pend_valid=1: done<=1, y <= 1<<pend_code, y_valid stays 1, counter <= PULSE_LEN-1, pend_valid<=0, state stays HOLD. There is no gap cycle; done overlaps the first cycle of the new strobe.
  - Abort (en=0) and reset also clear pend_valid.
  - IDLE behaviour is unchanged.
- Disabled: no pending storage, and code_ready=0 throughout HOLD, exactly as described above.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with code_valid=1, code=5, en=1 -> y=0, y_valid=0, done=0, code_ready=0 throughout; no accept.
- Basic decode, PULSE_LEN=4, en=1: send code=3 for one cycle -> y=8'b00001000 for 4 cycles, then y=0 with done=1 for 1 cycle. Sweep codes 0..7 -> y=8'b00000001 .. 8'b10000000.
- Back-to-back, PULSE_LEN=4: code_valid held high with code=6 then 1 -> 8'b01000000 x4, one zero cycle with done=1, then 8'b00000010 x4, then done; y is never non-one-hot.
- Abort: accept code=7, drop en in the 2nd HOLD cycle -> y=0 at the next edge, done never pulses, code_ready=0 while en=0; re-raise en and accept code=2 -> 8'b00000100 x4.
- PULSE_LEN=1: codes 4 then 0, back-to-back -> pattern y=8'b00010000, 0 (done), 8'b00000001, 0 (done).
- With DECODER38_PENDING_EN: accept code=2, then code=5 during HOLD -> 8'b00000100 x4 immediately followed by 8'b00100000 x4, done high in the first 8'b00100000 cycle and again after it. A third code offered during the first strobe sees code_ready=0.
